// File: rtl/csr_reg_block.sv
// csr_reg_block: 8-entry word-indexed CSR map behind the bus bridge request port.
// Every accepted access answers exactly one cycle later; requests seen while answering are ignored.
module csr_reg_block #(
    parameter int unsigned           ADDR_WIDTH = 3,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic [DATA_WIDTH-1:0] bus_wr_biten,
    output logic                  bus_ready,
    output logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  bus_err,
    input  logic [DATA_WIDTH-1:0] hw_status_i,
    input  logic [DATA_WIDTH-1:0] hw_event_i,
    output logic [DATA_WIDTH-1:0] ctrl_o,
    output logic                  irq_o
);

    localparam logic [ADDR_WIDTH-1:0] IDX_CTRL    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] IDX_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_IRQ_ST  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] IDX_IRQ_EN  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] IDX_SCRATCH = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] IDX_EVT_CNT = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] IDX_VERSION = ADDR_WIDTH'(6);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    accept;
    logic                    acc_err;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [DATA_WIDTH-1:0]   wr_bits;

    logic [DATA_WIDTH-1:0]   ctrl_q,     ctrl_d;
    logic [DATA_WIDTH-1:0]   irq_st_q,   irq_st_d;
    logic [DATA_WIDTH-1:0]   irq_en_q,   irq_en_d;
    logic [DATA_WIDTH-1:0]   scratch_q,  scratch_d;
    logic [DATA_WIDTH-1:0]   evt_cnt_q,  evt_cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q,  rsp_err_d;
    logic                    irq_q,      irq_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_req) begin
                    accept  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data and error are decoded every cycle but only captured on accept.
    always_comb begin
        rd_val  = '0;
        acc_err = 1'b0;
        case (bus_addr)
            IDX_CTRL:    rd_val = ctrl_q;
            IDX_STATUS:  rd_val = hw_status_i;
            IDX_IRQ_ST:  rd_val = irq_st_q;
            IDX_IRQ_EN:  rd_val = irq_en_q;
            IDX_SCRATCH: rd_val = scratch_q;
            IDX_EVT_CNT: rd_val = evt_cnt_q;
            IDX_VERSION: rd_val = VERSION;
            default:     acc_err = 1'b1;
        endcase
        if (bus_req_is_wr) begin
            rd_val = '0;
            if (bus_addr == IDX_STATUS || bus_addr == IDX_VERSION) begin
                acc_err = 1'b1;
            end
        end
        if (acc_err) begin
            rd_val = '0;
        end
    end

    assign wr_en   = accept & bus_req_is_wr & ~acc_err;
    assign wr_bits = bus_wr_data & bus_wr_biten;

    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        irq_st_d  = irq_st_q;
        evt_cnt_d = evt_cnt_q;
        if (wr_en && bus_addr == IDX_CTRL) begin
            ctrl_d = (ctrl_q & ~bus_wr_biten) | wr_bits;
        end
        if (wr_en && bus_addr == IDX_IRQ_EN) begin
            irq_en_d = (irq_en_q & ~bus_wr_biten) | wr_bits;
        end
        if (wr_en && bus_addr == IDX_SCRATCH) begin
            scratch_d = (scratch_q & ~bus_wr_biten) | wr_bits;
        end
        // Clear first, then OR in events so a same-cycle hardware set wins.
        if (wr_en && bus_addr == IDX_IRQ_ST) begin
            irq_st_d = irq_st_q & ~wr_bits;
        end
        irq_st_d = irq_st_d | hw_event_i;
        if (hw_event_i[0] && evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + DATA_WIDTH'(1);
        end
        if (wr_en && bus_addr == IDX_EVT_CNT && bus_wr_biten != '0) begin
            evt_cnt_d = '0;
        end
    end

    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            rsp_data_d = rd_val;
            rsp_err_d  = acc_err;
        end
        irq_d = |(irq_st_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            irq_st_q   <= '0;
            irq_en_q   <= '0;
            scratch_q  <= '0;
            evt_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_st_q   <= irq_st_d;
            irq_en_q   <= irq_en_d;
            scratch_q  <= scratch_d;
            evt_cnt_q  <= evt_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            irq_q      <= irq_d;
        end
    end

    assign bus_ready   = (state_q == ST_RESP);
    assign bus_rd_data = bus_ready ? rsp_data_q : '0;
    assign bus_err     = bus_ready & rsp_err_q;
    assign ctrl_o      = ctrl_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_csr_reg_block.sv
// Scoreboard bench for csr_reg_block: drivers queue expected responses,
// a negedge monitor pops and compares them, including the response cycle.
module tb_csr_reg_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_req_is_wr;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_wr_biten;
    logic        bus_ready;
    logic [31:0] bus_rd_data;
    logic        bus_err;
    logic [31:0] hw_status_i;
    logic [31:0] hw_event_i;
    logic [31:0] ctrl_o;
    logic        irq_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    csr_reg_block dut (
        .clk           (clk),
        .rst           (rst),
        .bus_req       (bus_req),
        .bus_req_is_wr (bus_req_is_wr),
        .bus_addr      (bus_addr),
        .bus_wr_data   (bus_wr_data),
        .bus_wr_biten  (bus_wr_biten),
        .bus_ready     (bus_ready),
        .bus_rd_data   (bus_rd_data),
        .bus_err       (bus_err),
        .hw_status_i   (hw_status_i),
        .hw_event_i    (hw_event_i),
        .ctrl_o        (ctrl_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: compares every bus_ready against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (bus_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_ready cyc=%0d data=%h err=%b", cyc, bus_rd_data, bus_err);
            end else begin
                e = exp_q.pop_front();
                if (bus_rd_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
                    n_miss++;
                    $display("FAIL %s: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                             e.name, bus_rd_data, bus_err, cyc, e.data, e.err, e.cyc);
                end
            end
        end else if (rst === 1'b0) begin
            n_vec++;
            if (bus_rd_data !== 32'h0 || bus_err !== 1'b0) begin
                n_miss++;
                $display("FAIL idle_outputs cyc=%0d: got data=%h err=%b, want 0/0", cyc, bus_rd_data, bus_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the request for one cycle and queues the answer.
    task automatic req_start(input logic wr, input logic [2:0] addr, input logic [31:0] wd,
                             input logic [31:0] be, input logic [31:0] evt,
                             input logic [31:0] exp_d, input logic exp_e, input string name);
        exp_t e;
        bus_req       = 1'b1;
        bus_req_is_wr = wr;
        bus_addr      = addr;
        bus_wr_data   = wd;
        bus_wr_biten  = be;
        hw_event_i    = evt;
        e.data = exp_d;
        e.err  = exp_e;
        e.cyc  = cyc + 1;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        bus_req    = 1'b0;
        hw_event_i = '0;
    endtask

    task automatic acc(input logic wr, input logic [2:0] addr, input logic [31:0] wd,
                       input logic [31:0] be, input logic [31:0] exp_d, input logic exp_e,
                       input string name);
        req_start(wr, addr, wd, be, 32'h0, exp_d, exp_e, name);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] evt);
        hw_event_i = evt;
        @(negedge clk);
        hw_event_i = '0;
    endtask

    initial begin
        rst = 1'b1; bus_req = 1'b0; bus_req_is_wr = 1'b0; bus_addr = '0;
        bus_wr_data = '0; bus_wr_biten = '0; hw_status_i = 32'hCAFE_0123; hw_event_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'h0, bus_ready}, 32'h0);
        chk("reset_ctrl_o", ctrl_o, 32'h0);
        chk("reset_irq_o", {31'h0, irq_o}, 32'h0);

        acc(1'b0, 3'd6, 0, 0, 32'h0001_0000, 1'b0, "rd_version");
        acc(1'b0, 3'd1, 0, 0, 32'hCAFE_0123, 1'b0, "rd_status");

        acc(1'b1, 3'd4, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h0, 1'b0, "wr_scratch");
        acc(1'b0, 3'd4, 0, 0, 32'hDEAD_0000, 1'b0, "rd_scratch");
        acc(1'b1, 3'd4, 32'h1234_5678, 32'h0, 32'h0, 1'b0, "wr_scratch_biten0");
        acc(1'b0, 3'd4, 0, 0, 32'hDEAD_0000, 1'b0, "rd_scratch_biten0");

        req_start(1'b1, 3'd0, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, "wr_ctrl");
        chk("ctrl_o_after_accept", ctrl_o, 32'h5);
        @(negedge clk);
        acc(1'b0, 3'd0, 0, 0, 32'h5, 1'b0, "rd_ctrl");

        pulse(32'h3);
        acc(1'b0, 3'd2, 0, 0, 32'h3, 1'b0, "rd_irq_status");
        chk("irq_o_disabled", {31'h0, irq_o}, 32'h0);
        acc(1'b1, 3'd3, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr_irq_enable");
        chk("irq_o_enabled", {31'h0, irq_o}, 32'h1);
        req_start(1'b1, 3'd2, 32'h2, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, "w1c_collide");
        @(negedge clk);
        acc(1'b0, 3'd2, 0, 0, 32'h3, 1'b0, "rd_irq_set_wins");
        acc(1'b1, 3'd2, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, "w1c_bit0");
        acc(1'b0, 3'd2, 0, 0, 32'h2, 1'b0, "rd_irq_after_w1c");
        chk("irq_o_still_set", {31'h0, irq_o}, 32'h1);
        acc(1'b1, 3'd2, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b0, "w1c_bit1");
        chk("irq_o_cleared", {31'h0, irq_o}, 32'h0);

        // Counter picked up one event from the 0x3 pulse; clear it to start clean.
        acc(1'b0, 3'd5, 0, 0, 32'h1, 1'b0, "rd_evt_cnt_init");
        acc(1'b1, 3'd5, 32'h0, 32'h1, 32'h0, 1'b0, "clr_evt_cnt0");
        for (int i = 0; i < 5; i++) begin
            pulse(32'h1);
            @(negedge clk);
        end
        acc(1'b0, 3'd5, 0, 0, 32'h5, 1'b0, "rd_evt_cnt5");
        acc(1'b1, 3'd5, 32'h0, 32'h0, 32'h0, 1'b0, "wr_evt_cnt_biten0");
        acc(1'b0, 3'd5, 0, 0, 32'h5, 1'b0, "rd_evt_cnt_kept");
        acc(1'b1, 3'd5, 32'h0, 32'h1, 32'h0, 1'b0, "clr_evt_cnt");
        acc(1'b0, 3'd5, 0, 0, 32'h0, 1'b0, "rd_evt_cnt_clr");
        pulse(32'h1);
        req_start(1'b1, 3'd5, 32'h0, 32'h1, 32'h1, 32'h0, 1'b0, "clr_vs_inc");
        @(negedge clk);
        acc(1'b0, 3'd5, 0, 0, 32'h0, 1'b0, "rd_clear_wins");
        force dut.evt_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.evt_cnt_q;
        pulse(32'h1);
        acc(1'b0, 3'd5, 0, 0, 32'hFFFF_FFFF, 1'b0, "rd_evt_cnt_sat");

        acc(1'b1, 3'd1, 32'h1234, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_status_err");
        acc(1'b0, 3'd1, 0, 0, 32'hCAFE_0123, 1'b0, "rd_status_after_err");
        acc(1'b1, 3'd6, 32'h1234, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_version_err");
        acc(1'b0, 3'd6, 0, 0, 32'h0001_0000, 1'b0, "rd_version_after_err");
        acc(1'b0, 3'd7, 0, 0, 32'h0, 1'b1, "rd_unmapped");
        acc(1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_unmapped");

        // Request held for 4 cycles: accepts in cycles 1 and 3, answers in 2 and 4.
        begin
            exp_t e;
            bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 3'd6;
            e.data = 32'h0001_0000; e.err = 1'b0; e.cyc = cyc + 1; e.name = "held_req_a";
            exp_q.push_back(e);
            e.cyc = cyc + 3; e.name = "held_req_b";
            exp_q.push_back(e);
            repeat (4) @(negedge clk);
            bus_req = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Reset during RESP drops the response and clears the map.
        req_start(1'b1, 3'd0, 32'hA5, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, "wr_before_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drops_ready", {31'h0, bus_ready}, 32'h0);
        bus_req = 1'b1; bus_req_is_wr = 1'b1; bus_addr = 3'd4;
        bus_wr_data = 32'h5555_5555; bus_wr_biten = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl_o", ctrl_o, 32'h0);
        chk("rst_irq_o", {31'h0, irq_o}, 32'h0);
        acc(1'b0, 3'd0, 0, 0, 32'h0, 1'b0, "rst_rd_ctrl");
        acc(1'b0, 3'd2, 0, 0, 32'h0, 1'b0, "rst_rd_irq_status");
        acc(1'b0, 3'd3, 0, 0, 32'h0, 1'b0, "rst_rd_irq_enable");
        acc(1'b0, 3'd4, 0, 0, 32'h0, 1'b0, "rst_rd_scratch");
        acc(1'b0, 3'd5, 0, 0, 32'h0, 1'b0, "rst_rd_evt_cnt");

        repeat (3) @(negedge clk);
        chk("pending_responses", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule

// File: doc/csr_reg_block.md
# csr_reg_block

Register block sitting directly downstream of the APB4 slave bridge: consumes its internal bus request (`bus_req`, address, write data, bit-enables) and returns `bus_ready`/`bus_rd_data`/`bus_err`. Implements an 8-entry word-indexed register map with RW, RO, W1C and saturating-counter registers, a hardware-facing control output and an interrupt line. Every accepted access completes with a fixed one-cycle response latency. No stall is ever generated.

## Interface
- `ADDR_WIDTH`, 3, word index width; map occupies indices 0..7.
- `DATA_WIDTH`, 32, register and bus data width.
- `VERSION`, 32'h0001_0000, constant returned by VERSION register (DATA_WIDTH bits).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bus_req`  in  1  request valid from bridge.
- `bus_req_is_wr`  in  1  1 = write, 0 = read.
- `bus_addr`  in  ADDR_WIDTH  register word index.
- `bus_wr_data`  in  DATA_WIDTH  write data.
- `bus_wr_biten`  in  DATA_WIDTH  per-bit write enable.
- `bus_ready`  out  1  response strobe, one cycle wide.
- `bus_rd_data`  out  DATA_WIDTH  read data, valid only with `bus_ready`, else 0.
- `bus_err`  out  1  error response, valid only with `bus_ready`, else 0.
- `hw_status_i`  in  DATA_WIDTH  live hardware status, read via STATUS.
- `hw_event_i`  in  DATA_WIDTH  per-bit single-cycle event pulses.
- `ctrl_o`  out  DATA_WIDTH  current CTRL register value.
- `irq_o`  out  1  registered `|(IRQ_STATUS & IRQ_ENABLE)`.

## Operation
- Register map (index: name, type, reset):
  - 0: CTRL, RW, 0. Drives `ctrl_o`.
  - 1: STATUS, RO, reads `hw_status_i` sampled in accept cycle.
  - 2: IRQ_STATUS, W1C, 0. Bit n set on `hw_event_i[n]`. Write clears bits where `bus_wr_data & bus_wr_biten` = 1.
  - 3: IRQ_ENABLE, RW, 0.
  - 4: SCRATCH, RW, 0.
  - 5: EVENT_COUNT, RO + write-to-clear, 0. +1 per cycle with `hw_event_i[0]`=1, saturating at all-ones. Any write with `bus_wr_biten` != 0 clears it.
  - 6: VERSION, RO, `VERSION`.
  - 7: unmapped.
- RW write: `reg <= (reg & ~biten) | (wdata & biten)`. Biten all zero: no change, no error.
- Errors (`bus_err`=1 with `bus_ready`): write to index 1 or 6; any access to index 7. Erroring writes have no side effect. Erroring reads return 0.
- Write responses return `bus_rd_data` = 0.
- FSM, two states:
  - IDLE: `bus_req`=1 accepts the request → RESP.
  - RESP: `bus_ready`=1, `bus_rd_data`/`bus_err` driven from response register → IDLE unconditionally. `bus_req` is ignored in RESP.
- Simultaneous events:
  - IRQ_STATUS: hardware set and W1C clear on same bit in same cycle → set wins (bit = 1).
  - EVENT_COUNT: clear and increment in same cycle → clear wins (value 0).

## Timing
- Reset values: state IDLE, all registers per map, `bus_ready`=0, `bus_rd_data`=0, `bus_err`=0, `ctrl_o`=0, `irq_o`=0.
- Accept edge: write side effects commit, and read data plus error flag are captured, at the rising edge ending the cycle in which IDLE sees `bus_req`=1.
- Latency: `bus_ready` is high exactly the next cycle after accept, for one cycle.
- Throughput: back-to-back requests at most every 2 cycles.
- A `bus_req` still high in the cycle after `bus_ready` is a new request; the bridge must drop it.
- Register updates:
  - `ctrl_o` reflects a CTRL write in the cycle after the accept edge.
  - `irq_o` updates one cycle after IRQ_STATUS or IRQ_ENABLE changes.
  - An event in cycle t is visible in IRQ_STATUS and EVENT_COUNT from cycle t+1.
- Reset mid-operation: a pending RESP is dropped and no `bus_ready` is issued. A write accepted at the same edge as `rst`=1 does not commit (reset wins).

## Test plan
- Reset, then read index 6 → `bus_ready` one cycle after accept, `bus_rd_data`=0x0001_0000, `bus_err`=0. Outputs all 0 before the first request.
- Write SCRATCH 0xDEAD_BEEF with biten 0xFFFF_0000 over reset value 0 → readback 0xDEAD_0000. Write CTRL 0x5 with full biten → `ctrl_o`=0x5 the cycle after accept.
- Pulse `hw_event_i`=0x3 → IRQ_STATUS=0x3. Write IRQ_ENABLE 0x2 → `irq_o`=1. Write IRQ_STATUS data 0x2 (W1C) while `hw_event_i[1]` pulses in the accept cycle → IRQ_STATUS stays 0x3.
- Pulse `hw_event_i[0]` 5 times → EVENT_COUNT=5. Write index 5 with biten 0x1 → reads 0. Force the counter to all-ones plus one event → stays 0xFFFF_FFFF.
- Errors:
  - Write 0x1234 to STATUS → `bus_err`=1, no change.
  - Read index 7 → `bus_err`=1, `bus_rd_data`=0.
  - Hold `bus_req` high 4 cycles → `bus_ready` pulses in cycles 2 and 4 only.
- Assert `rst` in the RESP cycle → no `bus_ready` in the following cycle, and all registers read back their reset values.
